// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the fetch/data memory-port arbiter.
package mem_port_arbiter_pkg;

  localparam int ARB_ADDR_W = 32;
  localparam int ARB_DATA_W = 32;
  localparam int ARB_SEL_W  = ARB_DATA_W / 8;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_BUSY_IF  = 2'd1,
    ST_BUSY_MEM = 2'd2,
    ST_RESP     = 2'd3
  } arb_state_t;

  typedef enum logic {
    GRANT_IF  = 1'b0,
    GRANT_MEM = 1'b1
  } grant_t;

  localparam logic CHIP_ENABLE   = 1'b1;
  localparam logic CHIP_DISABLE  = 1'b0;
  localparam logic WRITE_ENABLE  = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;

  // Data side wins a tie unless it had the previous grant, so contention alternates.
  function automatic grant_t pick_grant(logic if_req, logic mem_req, grant_t last_grant);
    if (mem_req && (!if_req || last_grant == GRANT_IF)) return GRANT_MEM;
    return GRANT_IF;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester-side and external-RAM-side signals of the memory-port arbiter.
interface mem_port_arbiter_if
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = ARB_ADDR_W,
  parameter int DATA_W = ARB_DATA_W,
  parameter int SEL_W  = ARB_SEL_W
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_done;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [SEL_W-1:0]  mem_sel;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_done;
  logic              ram_ce;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [SEL_W-1:0]  ram_sel;
  logic [DATA_W-1:0] ram_rdata;
  logic              ram_ack;
  logic              stall_if;
  logic              stall_mem;

  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, mem_sel,
           ram_rdata, ram_ack,
    output if_rdata, if_done, mem_rdata, mem_done,
           ram_ce, ram_we, ram_addr, ram_wdata, ram_sel, stall_if, stall_mem
  );

  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, mem_sel,
           ram_rdata, ram_ack,
    input  if_rdata, if_done, mem_rdata, mem_done,
           ram_ce, ram_we, ram_addr, ram_wdata, ram_sel, stall_if, stall_mem
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Serialises instruction-fetch and data accesses onto one external memory port.
//   state       | meaning
//   ST_IDLE     | arbitrate between sampled fetch and data requests
//   ST_BUSY_IF  | fetch on the RAM port, waiting for ram_ack
//   ST_BUSY_MEM | load/store on the RAM port, waiting for ram_ack
//   ST_RESP     | one-cycle done pulse, requests ignored
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = ARB_ADDR_W,
  parameter int DATA_W = ARB_DATA_W,
  parameter int SEL_W  = ARB_SEL_W
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.slave  bus
);

  arb_state_t        state_q, state_d;
  grant_t            last_grant_q;
  logic              grant_if, grant_mem;
  logic              ack_if, ack_mem;
  logic              ram_ce_q, ram_we_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] ram_wdata_q;
  logic [SEL_W-1:0]  ram_sel_q;
  logic [DATA_W-1:0] if_rdata_q, mem_rdata_q;
  logic              if_done_q, mem_done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    grant_if  = 1'b0;
    grant_mem = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.if_req || bus.mem_req) begin
          if (pick_grant(bus.if_req, bus.mem_req, last_grant_q) == GRANT_MEM) begin
            grant_mem = 1'b1;
            state_d   = ST_BUSY_MEM;
          end else begin
            grant_if = 1'b1;
            state_d  = ST_BUSY_IF;
          end
        end
      end
      ST_BUSY_IF, ST_BUSY_MEM: if (bus.ram_ack) state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign ack_if  = (state_q == ST_BUSY_IF)  && bus.ram_ack;
  assign ack_mem = (state_q == ST_BUSY_MEM) && bus.ram_ack;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= GRANT_IF;
      ram_ce_q     <= CHIP_DISABLE;
      ram_we_q     <= WRITE_DISABLE;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      ram_sel_q    <= '0;
      if_rdata_q   <= '0;
      mem_rdata_q  <= '0;
      if_done_q    <= 1'b0;
      mem_done_q   <= 1'b0;
    end else begin
      if_done_q  <= ack_if;
      mem_done_q <= ack_mem;
      if (grant_mem) begin
        ram_ce_q     <= CHIP_ENABLE;
        ram_we_q     <= bus.mem_we;
        ram_addr_q   <= bus.mem_addr;
        ram_wdata_q  <= bus.mem_wdata;
        ram_sel_q    <= bus.mem_sel;
        last_grant_q <= GRANT_MEM;
      end else if (grant_if) begin
        ram_ce_q     <= CHIP_ENABLE;
        ram_we_q     <= WRITE_DISABLE;
        ram_addr_q   <= bus.if_addr;
        ram_wdata_q  <= '0;
        ram_sel_q    <= '1;
        last_grant_q <= GRANT_IF;
      end else if (ack_if || ack_mem) begin
        ram_ce_q <= CHIP_DISABLE;
        ram_we_q <= WRITE_DISABLE;
      end
      if (ack_if) if_rdata_q <= bus.ram_rdata;
      // Stores keep the previous load value visible on mem_rdata.
      if (ack_mem && !ram_we_q) mem_rdata_q <= bus.ram_rdata;
    end
  end

  assign bus.ram_ce    = ram_ce_q;
  assign bus.ram_we    = ram_we_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wdata = ram_wdata_q;
  assign bus.ram_sel   = ram_sel_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.mem_rdata = mem_rdata_q;
  assign bus.if_done   = if_done_q;
  assign bus.mem_done  = mem_done_q;
  assign bus.stall_if  = bus.if_req  & ~if_done_q;
  assign bus.stall_mem = bus.mem_req & ~mem_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Cycle-stepped scoreboard bench: expected RAM accesses and done pulses are queued and popped as the DUT acts.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  typedef struct {
    logic        is_mem;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    logic [31:0] rdata;
  } acc_t;

  typedef struct {
    logic is_mem;
    int   cyc;
  } resp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .SEL_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  acc_t        exp_q[$];
  resp_t       resp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          if_left  = 0, mem_left = 0;
  bit          if_late  = 0, mem_late = 0;
  bit          if_drop_pend = 0, mem_drop_pend = 0;
  bit          r_active = 0;
  int          r_wait   = 0;
  acc_t        r_cur;
  int          ack_delay = 1;
  bit          stray = 0;
  logic [31:0] model_if = '0, model_mem = '0;
  int          first_done = -1, last_done = -1;
  int          t0;

  task automatic chk(string tag, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ram_val(logic [31:0] a);
    if (a == 32'h4) return 32'h0010_0093;
    return {a[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction

  function automatic acc_t mk(logic is_mem, logic we, logic [31:0] addr,
                              logic [31:0] wdata, logic [3:0] sel);
    acc_t a;
    a.is_mem = is_mem;
    a.we     = we;
    a.addr   = addr;
    a.wdata  = wdata;
    a.sel    = is_mem ? sel : 4'hF;
    a.rdata  = ram_val(addr);
    return a;
  endfunction

  task automatic monitor();
    resp_t r;
    logic  exp_if, exp_mem;
    exp_if  = 1'b0;
    exp_mem = 1'b0;
    if (resp_q.size() > 0 && resp_q[0].cyc == cyc) begin
      r       = resp_q.pop_front();
      exp_if  = !r.is_mem;
      exp_mem = r.is_mem;
    end
    chk("if_done", bus.if_done, exp_if);
    chk("mem_done", bus.mem_done, exp_mem);
    chk("stall_if", bus.stall_if, bus.if_req & ~exp_if);
    chk("stall_mem", bus.stall_mem, bus.mem_req & ~exp_mem);
    chk("if_rdata", bus.if_rdata, model_if);
    chk("mem_rdata", bus.mem_rdata, model_mem);
    if (exp_if || exp_mem) begin
      chk("ce_in_resp", bus.ram_ce, 1'b0);
      if (first_done < 0) first_done = cyc;
      last_done = cyc;
    end
  endtask

  task automatic responder();
    if (bus.ram_ack) begin
      bus.ram_ack   = 1'b0;
      bus.ram_rdata = 32'hBAD0_BAD0;
    end
    if (r_active && (rst || !bus.ram_ce)) begin
      r_active = 0;
    end else if (!r_active && bus.ram_ce && !rst) begin
      if (exp_q.size() == 0) chk("unexpected_grant", 1'b1, 1'b0);
      else begin
        r_cur    = exp_q.pop_front();
        r_active = 1;
        r_wait   = ack_delay;
      end
    end
    if (r_active) begin
      chk("ram_ce", bus.ram_ce, 1'b1);
      chk("ram_we", bus.ram_we, r_cur.we);
      chk("ram_addr", bus.ram_addr, r_cur.addr);
      chk("ram_sel", bus.ram_sel, r_cur.sel);
      if (r_cur.we) chk("ram_wdata", bus.ram_wdata, r_cur.wdata);
      if (r_wait == 0) begin
        bus.ram_ack   = 1'b1;
        bus.ram_rdata = r_cur.rdata;
        resp_q.push_back('{is_mem: r_cur.is_mem, cyc: cyc + 1});
        if (!r_cur.is_mem) model_if = r_cur.rdata;
        else if (!r_cur.we) model_mem = r_cur.rdata;
        r_active = 0;
      end else begin
        r_wait--;
      end
    end else if (stray) begin
      bus.ram_ack   = 1'b1;
      bus.ram_rdata = 32'h1234_5678;
    end
  endtask

  task automatic requesters();
    if (if_drop_pend) begin bus.if_req = 1'b0; if_drop_pend = 0; end
    if (mem_drop_pend) begin bus.mem_req = 1'b0; mem_drop_pend = 0; end
    if (bus.if_done && if_left > 0) begin
      if_left--;
      if (if_left == 0) begin
        if (if_late) if_drop_pend = 1;
        else bus.if_req = 1'b0;
      end else bus.if_addr = bus.if_addr + 32'd4;
    end
    if (bus.mem_done && mem_left > 0) begin
      mem_left--;
      if (mem_left == 0) begin
        if (mem_late) mem_drop_pend = 1;
        else bus.mem_req = 1'b0;
      end else begin
        bus.mem_addr  = bus.mem_addr + 32'd4;
        bus.mem_wdata = bus.mem_wdata + 32'd1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    monitor();
    responder();
    requesters();
  endtask

  task automatic wait_all(string tag, int budget);
    int n = 0;
    while ((if_left > 0 || mem_left > 0 || r_active || exp_q.size() > 0 ||
            resp_q.size() > 0 || if_drop_pend || mem_drop_pend) && n < budget) begin
      tick();
      n++;
    end
    chk(tag, (n >= budget), 1'b0);
    tick();
    tick();
  endtask

  initial begin
    rst           = 1'b1;
    bus.if_req    = 1'b0;
    bus.if_addr   = '0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_sel   = '0;
    bus.ram_rdata = 32'hBAD0_BAD0;
    bus.ram_ack   = 1'b0;
    #2;
    chk("rst_ram_ce", bus.ram_ce, 1'b0);
    chk("rst_ram_we", bus.ram_we, 1'b0);
    chk("rst_ram_addr", bus.ram_addr, 32'h0);
    chk("rst_ram_wdata", bus.ram_wdata, 32'h0);
    chk("rst_ram_sel", bus.ram_sel, 4'h0);
    chk("rst_if_done", bus.if_done, 1'b0);
    chk("rst_mem_done", bus.mem_done, 1'b0);
    chk("rst_if_rdata", bus.if_rdata, 32'h0);
    chk("rst_mem_rdata", bus.mem_rdata, 32'h0);
    tick();
    tick();
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Fetch only, ack one cycle after the strobe: done three cycles after the request.
    ack_delay = 1;
    exp_q.push_back(mk(1'b0, 1'b0, 32'h4, 32'h0, 4'hF));
    bus.if_addr = 32'h4;
    bus.if_req  = 1'b1;
    if_left     = 1;
    t0          = cyc;
    tick();
    chk("t1_ce_cycle1", bus.ram_ce, 1'b1);
    wait_all("t1_timeout", 20);
    chk("t1_latency", last_done - t0, 3);

    // Simultaneous requests after a fetch grant: store first, then fetch.
    exp_q.push_back(mk(1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 4'h3));
    exp_q.push_back(mk(1'b0, 1'b0, 32'h8, 32'h0, 4'hF));
    bus.mem_we    = 1'b1;
    bus.mem_addr  = 32'h100;
    bus.mem_wdata = 32'hDEAD_BEEF;
    bus.mem_sel   = 4'h3;
    bus.if_addr   = 32'h8;
    bus.mem_req   = 1'b1;
    bus.if_req    = 1'b1;
    mem_left      = 1;
    if_left       = 1;
    wait_all("t2_timeout", 30);

    // Continuous contention with immediate acks: strict alternation at one access per 3 cycles.
    ack_delay  = 0;
    first_done = -1;
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(mk(1'b1, 1'b0, 32'h400 + 32'(4 * k), 32'h0, 4'hC));
      exp_q.push_back(mk(1'b0, 1'b0, 32'h40 + 32'(4 * k), 32'h0, 4'hF));
    end
    bus.mem_we   = 1'b0;
    bus.mem_addr = 32'h400;
    bus.mem_sel  = 4'hC;
    bus.if_addr  = 32'h40;
    bus.mem_req  = 1'b1;
    bus.if_req   = 1'b1;
    mem_left     = 3;
    if_left      = 3;
    wait_all("t3_timeout", 60);
    chk("t3_throughput", last_done - first_done, 15);

    // Slow ack; request held through RESP must not be re-granted.
    ack_delay = 5;
    mem_late  = 1;
    exp_q.push_back(mk(1'b1, 1'b0, 32'h180, 32'h0, 4'h6));
    bus.mem_addr = 32'h180;
    bus.mem_sel  = 4'h6;
    bus.mem_req  = 1'b1;
    mem_left     = 1;
    wait_all("t4_timeout", 30);
    mem_late = 0;

    // Reset during a data access: abandoned, then a pending fetch is served.
    ack_delay = 8;
    exp_q.push_back(mk(1'b1, 1'b0, 32'h200, 32'h0, 4'hF));
    exp_q.push_back(mk(1'b0, 1'b0, 32'h300, 32'h0, 4'hF));
    bus.mem_addr = 32'h200;
    bus.mem_sel  = 4'hF;
    bus.mem_req  = 1'b1;
    mem_left     = 1;
    tick();
    tick();
    bus.if_addr = 32'h300;
    bus.if_req  = 1'b1;
    if_left     = 1;
    tick();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t5_ce_async", bus.ram_ce, 1'b0);
    chk("t5_we_async", bus.ram_we, 1'b0);
    chk("t5_mem_done", bus.mem_done, 1'b0);
    chk("t5_if_rdata", bus.if_rdata, 32'h0);
    chk("t5_mem_rdata", bus.mem_rdata, 32'h0);
    model_if    = '0;
    model_mem   = '0;
    bus.mem_req = 1'b0;
    mem_left    = 0;
    ack_delay   = 2;
    tick();
    tick();
    @(negedge clk);
    rst = 1'b0;
    wait_all("t5_timeout", 30);

    // Stray ack while idle: nothing changes.
    stray = 1;
    tick();
    tick();
    tick();
    stray = 0;
    chk("t6_ce_idle", bus.ram_ce, 1'b0);
    tick();
    tick();

    chk("exp_q_empty", 64'(exp_q.size()), 64'd0);
    chk("resp_q_empty", 64'(resp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
